// File: rtl/vga_fb_reader.sv
// vga_fb_reader: display-side reader for the dual-clock frame buffer.
// Generates VGA timing on the pixel clock, drives the buffer read port
// (one-cycle read latency) and delivers pixel/hsync/vsync/de aligned with
// a fixed 3-clock pipeline latency.
// Optional build macro: FB_READER_TEST_PATTERN_EN adds an 8-bar test
// pattern selected at run time by i_pattern.
//
// Handshake: there is no valid/ready pair here. o_rd is a plain read
// strobe; the buffer answers on i_bram_data exactly one clock after it
// samples o_rd/o_rd_addr, with no back-pressure in either direction.
module vga_fb_reader #(
    parameter int WIDTH    = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DEPTH    = H_ACTIVE * V_ACTIVE
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_pattern,
    output logic                     o_rd,
    output logic [$clog2(DEPTH)-1:0] o_rd_addr,
    input  logic [WIDTH-1:0]         i_bram_data,
    output logic [WIDTH-1:0]         o_pixel,
    output logic                     o_hsync,
    output logic                     o_vsync,
    output logic                     o_de,
    output logic                     o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(DEPTH);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] addr_cnt;

    logic run, active, hs_n, vs_n, fs;
    logic pat_sel;
    logic [WIDTH-1:0] pat_val;

    // stage 1 / stage 2 alignment registers
    logic de_d1, de_d2, hs_d1, hs_d2, vs_d1, vs_d2, fs_d1, fs_d2;
    logic sel_d1, sel_d2;
    logic [WIDTH-1:0] pat_d1, pat_d2;

    // Per-cycle decode of the counter position into video timing signals
    always_comb begin
        run    = (state == ST_RUN);
        active = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_n   = !(run && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_n   = !(run && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
        fs     = run && (h_cnt == '0) && (v_cnt == '0);
    end

`ifdef FB_READER_TEST_PATTERN_EN
    localparam int CW    = WIDTH / 3;
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_k;

    // Bar index h/BAR_W by threshold compare; avoids a divider
    always_comb begin
        bar_k = '0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= HW'(i * BAR_W)) bar_k = 3'(i);
        end
        pat_sel = i_pattern;
        pat_val = {{CW{bar_k[2]}}, {CW{bar_k[1]}}, {CW{bar_k[0]}}};
    end
`else
    logic unused_pattern;

    // Pattern feature compiled out: selection is tied off
    always_comb begin
        pat_sel        = 1'b0;
        pat_val        = '0;
        unused_pattern = i_pattern;
    end
`endif

    // FSM plus h/v/linear-address counters; frame ends go IDLE when i_start is low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            h_cnt    <= '0;
            v_cnt    <= '0;
            addr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) state <= ST_RUN;
                end
                default: begin
                    if (active) addr_cnt <= (addr_cnt == A_LAST) ? '0 : addr_cnt + 1'b1;
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        if (v_cnt == V_LAST) begin
                            v_cnt <= '0;
                            if (!i_start) state <= ST_IDLE;
                        end else begin
                            v_cnt <= v_cnt + 1'b1;
                        end
                    end else begin
                        h_cnt <= h_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Three-stage output pipeline: read issue, buffer latency, pixel select
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd          <= 1'b0;
            o_rd_addr     <= '0;
            de_d1         <= 1'b0;
            de_d2         <= 1'b0;
            hs_d1         <= 1'b1;
            hs_d2         <= 1'b1;
            vs_d1         <= 1'b1;
            vs_d2         <= 1'b1;
            fs_d1         <= 1'b0;
            fs_d2         <= 1'b0;
            sel_d1        <= 1'b0;
            sel_d2        <= 1'b0;
            pat_d1        <= '0;
            pat_d2        <= '0;
            o_pixel       <= '0;
            o_de          <= 1'b0;
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            o_rd          <= active && !pat_sel;
            o_rd_addr     <= addr_cnt;
            de_d1         <= active;
            hs_d1         <= hs_n;
            vs_d1         <= vs_n;
            fs_d1         <= fs;
            sel_d1        <= pat_sel;
            pat_d1        <= pat_val;
            de_d2         <= de_d1;
            hs_d2         <= hs_d1;
            vs_d2         <= vs_d1;
            fs_d2         <= fs_d1;
            sel_d2        <= sel_d1;
            pat_d2        <= pat_d1;
            o_pixel       <= de_d2 ? (sel_d2 ? pat_d2 : i_bram_data) : '0;
            o_de          <= de_d2;
            o_hsync       <= hs_d2;
            o_vsync       <= vs_d2;
            o_frame_start <= fs_d2;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: randomized bench for vga_fb_reader on a scaled-down
// raster; a position-based reference model predicts every output.
module tb_vga_fb_reader;
  localparam int WIDTH = 12;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int DEPTH = HA * VA;
  localparam int AW = $clog2(DEPTH);
  localparam int BAR_W = HA / 8;

  logic clk = 1'b0;
  logic rst, start, pattern;
  logic rd;
  logic [AW-1:0] rd_addr;
  logic [WIDTH-1:0] bram_data, pixel;
  logic hsync, vsync, de, frame_start;

  int checks = 0;
  int errors = 0;

  vga_fb_reader #(
    .WIDTH(WIDTH), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pattern(pattern),
    .o_rd(rd), .o_rd_addr(rd_addr), .i_bram_data(bram_data),
    .o_pixel(pixel), .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
    .o_frame_start(frame_start)
  );

  // clock
  always #5 clk = ~clk;

  // buffer model: data = address, one-cycle latency, junk when not read
  always @(posedge clk) begin
    if (rd) bram_data <= WIDTH'(rd_addr);
    else bram_data <= WIDTH'($urandom);
  end

  // reference model: description of one counter cycle
  typedef struct {
    logic idle;
    logic act;
    logic hs;
    logic vs;
    logic fs;
    logic pat;
    int unsigned h;
    int unsigned addr;
  } ent_t;

  ent_t cyc[4];
  int pos = -1;

  function automatic ent_t describe(input int p);
    ent_t e;
    int unsigned h, v;
    e.idle = (p < 0);
    e.pat = 1'b0;
    if (p < 0) begin
      e.act = 0; e.hs = 1; e.vs = 1; e.fs = 0; e.h = 0; e.addr = 0;
    end else begin
      h = p % HT;
      v = p / HT;
      e.h = h;
      e.act = (h < HA) && (v < VA);
      e.hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
      e.vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
      e.fs = (p == 0);
      e.addr = (v * HA + h) % DEPTH;
    end
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] bar_color(input int unsigned h);
    int unsigned k;
    k = h / BAR_W;
    return {(k & 4) != 0 ? 4'hF : 4'h0, (k & 2) != 0 ? 4'hF : 4'h0,
            (k & 1) != 0 ? 4'hF : 4'h0};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) cyc[i] = describe(-1);
  end

  // model advance: one frame position per clock while running
  always @(posedge clk) begin
`ifdef FB_READER_TEST_PATTERN_EN
    cyc[0].pat = pattern;
`else
    cyc[0].pat = 1'b0;
`endif
    if (rst) begin
      pos = -1;
      for (int i = 0; i < 4; i++) cyc[i] = describe(-1);
    end else begin
      if (pos < 0 || pos == FRAME - 1) pos = start ? 0 : -1;
      else pos = pos + 1;
      cyc[3] = cyc[2];
      cyc[2] = cyc[1];
      cyc[1] = cyc[0];
      cyc[0] = describe(pos);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // scoreboard: compare outputs mid-cycle against the model
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_pix;
    check("rd", 32'(rd), 32'(cyc[1].act && !cyc[1].pat));
    if (cyc[1].act || cyc[1].idle) check("rd_addr", 32'(rd_addr), cyc[1].addr);
    check("de", 32'(de), 32'(cyc[3].act));
    check("hsync", 32'(hsync), 32'(cyc[3].hs));
    check("vsync", 32'(vsync), 32'(cyc[3].vs));
    check("frame_start", 32'(frame_start), 32'(cyc[3].fs));
    if (!cyc[3].act) exp_pix = '0;
    else if (cyc[3].pat) exp_pix = bar_color(cyc[3].h);
    else exp_pix = WIDTH'(cyc[3].addr);
    check("pixel", 32'(pixel), 32'(exp_pix));
  end

  task automatic run_cycles(input int n, input bit rand_pat);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rand_pat && $urandom_range(0, 31) == 0) pattern = ~pattern;
    end
  endtask

  // stimulus
  initial begin
    rst = 1'b1;
    start = 1'b1;
    pattern = 1'b0;
    bram_data = '0;
    run_cycles(5, 0);
    rst = 1'b0;
    // two clean frames of buffer data
    run_cycles(2 * FRAME + 10, 0);
    // one frame of pattern
    pattern = 1'b1;
    run_cycles(FRAME, 0);
    pattern = 1'b0;
    for (int ep = 0; ep < 16; ep++) begin
      case ($urandom_range(0, 2))
        0: run_cycles($urandom_range(50, 2 * FRAME), 1);
        1: begin
          start = 1'b0;
          run_cycles($urandom_range(1, FRAME + 60), 1);
          start = 1'b1;
          run_cycles($urandom_range(10, FRAME), 1);
        end
        default: begin
          run_cycles($urandom_range(1, FRAME), 1);
          rst = 1'b1;
          run_cycles($urandom_range(1, 3), 1);
          rst = 1'b0;
          run_cycles($urandom_range(10, FRAME), 1);
        end
      endcase
    end
    pattern = 1'b0;
    run_cycles(FRAME, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
